// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//  Bundles the fetch, data and memory-macro signals around the unified memory
//  port arbiter.
//  Modports:
//   master : the arbiter itself (samples requests and memory read data,
//            drives responses, pipeline write enables and the memory pins)
//   slave  : everything around it (front end, MEM stage, memory macro)
//  Signals:
//   if_req/if_addr                  fetch request and PC
//   if_rdata/if_valid               fetched instruction, 1-cycle complete pulse
//   d_rd/d_wr/d_addr/d_wdata        load/store request, address, store data
//   d_rdata/d_valid/d_stall         load data, complete pulse, back-end stall
//   pc_write/ifid_write             PC and IF/ID load enables
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory macro pins
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              d_rd;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_stall;
   logic              pc_write;
   logic              ifid_write;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_valid, d_rdata, d_valid, d_stall,
             pc_write, ifid_write, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_valid, d_rdata, d_valid, d_stall,
             pc_write, ifid_write, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//  Time-shares the single-ported unified instruction/data memory between the
//  fetch stage and the MEM stage. One requester is granted at a time, the
//  access runs for MEM_LAT cycles, and completion is reported with a 1-cycle
//  valid pulse. Data accesses normally win; after STARVE_MAX consecutive data
//  grants with a fetch waiting, the fetch is forced through.
//  Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : mem_port_arbiter_if.master (requests, responses, memory pins)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   mem_port_arbiter_if.master bus
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [STV_W-1:0]  r_starve;
   logic              r_d_read;     // granted data access is a pure read
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_valid;
   logic              r_d_valid;

   logic w_d_req;
   logic w_fetch_forced;

   assign w_d_req        = bus.d_rd | bus.d_wr;
   // Fetch has waited through STARVE_MAX data grants: it takes this slot.
   assign w_fetch_forced = bus.if_req && (r_starve == STV_TOP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_d_read    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_valid  <= 1'b0;
         r_d_valid   <= 1'b0;
      end else begin
         // Valid outputs are single-cycle pulses.
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_d_req && !w_fetch_forced) begin
                  r_state     <= BUSY_D;
                  r_cnt       <= CNT_INIT;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= bus.d_wr;   // rd+wr together is a write
                  r_mem_addr  <= bus.d_addr;
                  r_mem_wdata <= bus.d_wdata;
                  r_d_read    <= ~bus.d_wr;
                  if (bus.if_req)
                     r_starve <= (r_starve == STV_TOP) ? STV_TOP : r_starve + 1'b1;
                  else
                     r_starve <= '0;
               end else if (bus.if_req) begin
                  r_state    <= BUSY_I;
                  r_cnt      <= CNT_INIT;
                  r_mem_en   <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= bus.if_addr;
                  r_starve   <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_state  <= IDLE;
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  if (r_state == BUSY_I) begin
                     r_if_rdata <= bus.mem_rdata;
                     r_if_valid <= 1'b1;
                  end else begin
                     r_d_valid <= 1'b1;
                     if (r_d_read)
                        r_d_rdata <= bus.mem_rdata;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.if_rdata   = r_if_rdata;
   assign bus.if_valid   = r_if_valid;
   assign bus.pc_write   = r_if_valid;
   assign bus.ifid_write = r_if_valid;
   assign bus.d_rdata    = r_d_rdata;
   assign bus.d_valid    = r_d_valid;
   assign bus.d_stall    = w_d_req & ~r_d_valid;
   assign bus.mem_en     = r_mem_en;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//  Drives the arbiter through directed scenarios (single fetch, data-vs-fetch
//  priority, write, read+write, starvation, reset mid-fetch) and then a long
//  randomized run. A transaction-level reference model tracks each grant by
//  its grant cycle number and predicts every output cycle by cycle.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   localparam int M_RAND = 0;   // random requests, re-raised after completion
   localparam int M_HOLD = 1;   // requests drop after completion, nothing new
   localparam int M_CONT = 2;   // requests never drop

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_LAT   (MEM_LAT),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int                cyc = 0;
   int                grant_cyc = 0;
   int                starve = 0;
   int                txn = 0;
   bit                busy = 1'b0;
   bit                grant_d = 1'b0;
   bit                is_wr = 1'b0;
   bit                e_if_valid = 1'b0;
   bit                e_d_valid = 1'b0;
   logic [ADDR_W-1:0] e_mem_addr = '0;
   logic [DATA_W-1:0] e_mem_wdata = '0;
   logic [DATA_W-1:0] e_if_rdata = '0;
   logic [DATA_W-1:0] e_d_rdata = '0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      busy        = 1'b0;
      starve      = 0;
      e_if_valid  = 1'b0;
      e_d_valid   = 1'b0;
      e_mem_addr  = '0;
      e_mem_wdata = '0;
      e_if_rdata  = '0;
      e_d_rdata   = '0;
   endtask

   // One rising edge as seen by the model: an access granted at cycle G
   // completes at cycle G+MEM_LAT; requests are looked at only when idle.
   task automatic model_edge();
      bit d_req;
      cyc++;
      e_if_valid = 1'b0;
      e_d_valid  = 1'b0;
      if (busy) begin
         if (cyc == grant_cyc + MEM_LAT) begin
            busy = 1'b0;
            txn++;
            if (grant_d) begin
               e_d_valid = 1'b1;
               if (!is_wr) e_d_rdata = bus.mem_rdata;
               $display("txn %0d: data %s addr=%h wdata=%h rdata=%h", txn,
                        is_wr ? "write" : "read", e_mem_addr, e_mem_wdata, e_d_rdata);
            end else begin
               e_if_valid = 1'b1;
               e_if_rdata = bus.mem_rdata;
               $display("txn %0d: fetch addr=%h instr=%h", txn, e_mem_addr, e_if_rdata);
            end
         end
      end else begin
         d_req = bus.d_rd | bus.d_wr;
         if (d_req && !(bus.if_req && starve == STARVE_MAX)) begin
            busy        = 1'b1;
            grant_d     = 1'b1;
            grant_cyc   = cyc;
            is_wr       = bus.d_wr;
            e_mem_addr  = bus.d_addr;
            e_mem_wdata = bus.d_wdata;
            if (bus.if_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
            else            starve = 0;
         end else if (bus.if_req) begin
            busy       = 1'b1;
            grant_d    = 1'b0;
            grant_cyc  = cyc;
            is_wr      = 1'b0;
            e_mem_addr = bus.if_addr;
            starve     = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk_val("mem_en",     bus.mem_en,     busy);
      chk_val("mem_we",     bus.mem_we,     busy && is_wr);
      chk_val("mem_addr",   bus.mem_addr,   e_mem_addr);
      chk_val("mem_wdata",  bus.mem_wdata,  e_mem_wdata);
      chk_val("if_valid",   bus.if_valid,   e_if_valid);
      chk_val("pc_write",   bus.pc_write,   e_if_valid);
      chk_val("ifid_write", bus.ifid_write, e_if_valid);
      chk_val("if_rdata",   bus.if_rdata,   e_if_rdata);
      chk_val("d_valid",    bus.d_valid,    e_d_valid);
      chk_val("d_rdata",    bus.d_rdata,    e_d_rdata);
      chk_val("d_stall",    bus.d_stall,    (bus.d_rd | bus.d_wr) & ~e_d_valid);
   endtask

   task automatic drive(input int mode);
      logic [1:0] op;
      case (mode)
         M_RAND: begin
            if (!bus.if_req || e_if_valid)
               bus.if_req = ($urandom_range(3) != 0);
            if (!(bus.d_rd || bus.d_wr) || e_d_valid) begin
               op = 2'($urandom_range(3));
               bus.d_rd = op[0];
               bus.d_wr = op[1];
            end
            // Address/data wander freely; only the values at grant matter.
            bus.if_addr   = 16'($urandom);
            bus.d_addr    = 16'($urandom);
            bus.d_wdata   = 16'($urandom);
            bus.mem_rdata = 16'($urandom);
         end
         M_HOLD: begin
            if (e_if_valid) bus.if_req = 1'b0;
            if (e_d_valid) begin
               bus.d_rd = 1'b0;
               bus.d_wr = 1'b0;
            end
         end
         default: ;
      endcase
   endtask

   // One clock cycle: model follows the edge, outputs checked on the falling
   // edge, then new stimulus applied.
   task automatic step(input int mode);
      @(posedge clk);
      if (reset) model_edge();
      else       model_reset();
      @(negedge clk);
      compare_all();
      drive(mode);
   endtask

   task automatic run(input int n, input int mode);
      for (int i = 0; i < n; i++) step(mode);
   endtask

   initial begin
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_rd      = 1'b0;
      bus.d_wr      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;

      // Reset state
      run(3, M_HOLD);
      reset = 1'b1;

      // Single fetch
      bus.if_req = 1'b1; bus.if_addr = 16'h0010; bus.mem_rdata = 16'hA5A5;
      run(6, M_HOLD);

      // Data and fetch requested together: data first, then fetch
      bus.d_rd = 1'b1; bus.d_addr = 16'h8000; bus.mem_rdata = 16'h5A5A;
      bus.if_req = 1'b1; bus.if_addr = 16'h0012;
      run(10, M_HOLD);

      // Store
      bus.d_wr = 1'b1; bus.d_addr = 16'h8002; bus.d_wdata = 16'h1234; bus.mem_rdata = 16'hDEAD;
      run(6, M_HOLD);

      // Read and write together is a write
      bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h9000; bus.d_wdata = 16'h4321;
      bus.mem_rdata = 16'hBEEF;
      run(6, M_HOLD);

      // Continuous load + fetch: starvation limit forces a fetch in
      bus.d_rd = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h8004;
      bus.if_req = 1'b1; bus.if_addr = 16'h0020; bus.mem_rdata = 16'h0F0F;
      run(40, M_CONT);
      bus.d_rd = 1'b0; bus.if_req = 1'b0;
      run(6, M_HOLD);

      // Reset in the second cycle of a fetch
      bus.if_req = 1'b1; bus.if_addr = 16'h0030; bus.mem_rdata = 16'h7777;
      begin
         bit reached = 1'b0;
         for (int i = 0; i < 10 && !reached; i++) begin
            step(M_HOLD);
            if (busy && cyc == grant_cyc + 1) reached = 1'b1;
         end
         chk_val("t5_reach_fetch", reached, 1'b1);
      end
      #2 reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      run(2, M_HOLD);
      reset = 1'b1;
      run(8, M_HOLD);

      // Randomized traffic
      run(3000, M_RAND);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
